crypto1_key_collector: RTL

Collects candidate 48-bit Crypto1 keys from the array of Crypto1 search cores and delivers them to the host over a slow serial link. Sits directly downstream of the cores. It arbitrates round-robin among cores presenting a candidate and buffers accepted keys in a small FIFO. Each key is shifted out MSB-first on an externally driven KEY_CLK, and the block flags when the whole search has finished.

---
 rtl/crypto1_key_collector.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/crypto1_key_collector.sv
// rtl/crypto1_key_collector.sv - round-robin Crypto1 candidate collector, key FIFO and KEY_CLK serializer
// Optional macro KEY_DEDUP_EN: drop a granted candidate equal to the last accepted key.
module crypto1_key_collector #(
  parameter int NCORES     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic [NCORES-1:0]      CAND_VALID,
  input  logic [48*NCORES-1:0]   CAND_KEY,
  output logic [NCORES-1:0]      CAND_READY,
  input  logic [NCORES-1:0]      CORE_DONE,
  input  logic                   KEY_CLK,
  output logic                   KEY_DATA,
  output logic                   KEY_VALID,
  output logic                   ALL_DONE,
  output logic [15:0]            KEY_COUNT
);

  localparam int PW = $clog2(NCORES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = $clog2(48 * NCORES);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [47:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [47:0]   sh_q, sh_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic          ks1_q, ks2_q, ks3_q;
  logic          done_q, done_d;
  logic [15:0]   kcnt_q, kcnt_d;

  logic          fifo_full, fifo_empty, krise, pop, wr_en, gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   cand;
  logic [KW-1:0] key_base;
  logic [47:0]   gnt_key;

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign krise      = ks2_q & ~ks3_q;

  // First requesting core at or after ptr_q, wrapping modulo NCORES
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NCORES; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NCORES)) cand = cand - (PW+1)'(NCORES);
      if (!gnt_any && !fifo_full && CAND_VALID[cand[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    CAND_READY = '0;
    if (gnt_any) CAND_READY[gnt_idx] = 1'b1;
  end

  assign key_base = KW'(gnt_idx) * KW'(48);
  assign gnt_key  = CAND_KEY[key_base +: 48];

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == PW'(NCORES - 1)) ? '0 : gnt_idx + 1'b1;
  end

`ifdef KEY_DEDUP_EN
  logic [47:0] last_q, last_d;
  logic        last_v_q, last_v_d;

  always_comb begin
    last_d   = last_q;
    last_v_d = last_v_q;
    if (gnt_any) begin
      last_d   = gnt_key;
      last_v_d = 1'b1;
    end
  end

  // A repeated key is still consumed from the core, just not buffered
  assign wr_en = gnt_any & ~(last_v_q & (last_q == gnt_key));

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      last_q   <= '0;
      last_v_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      last_v_q <= last_v_d;
    end
  end
`else
  assign wr_en = gnt_any;
`endif

  // Serializer next state; a pop at bitcnt 0 reloads without leaving SHIFT
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          sh_d     = mem_q[rp_q];
          bitcnt_d = 6'd47;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (krise) begin
          if (bitcnt_q != 6'd0) begin
            sh_d     = {sh_q[46:0], 1'b0};
            bitcnt_d = bitcnt_q - 6'd1;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            sh_d     = mem_q[rp_q];
            bitcnt_d = 6'd47;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    KEY_VALID = (state_q == S_SHIFT);
    KEY_DATA  = (state_q == S_SHIFT) & sh_q[47];
  end

  always_comb begin
    wp_d   = wr_en ? wp_q + 1'b1 : wp_q;
    rp_d   = pop ? rp_q + 1'b1 : rp_q;
    cnt_d  = cnt_q + CW'(wr_en) - CW'(pop);
    kcnt_d = (wr_en && kcnt_q != 16'hFFFF) ? kcnt_q + 16'd1 : kcnt_q;
    done_d = done_q | (&CORE_DONE & ~|CAND_VALID & fifo_empty & (state_q == S_IDLE));
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      ptr_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      sh_q     <= '0;
      bitcnt_q <= '0;
      ks1_q    <= 1'b0;
      ks2_q    <= 1'b0;
      ks3_q    <= 1'b0;
      done_q   <= 1'b0;
      kcnt_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      ks1_q    <= KEY_CLK;
      ks2_q    <= ks1_q;
      ks3_q    <= ks2_q;
      done_q   <= done_d;
      kcnt_q   <= kcnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wp_q] <= gnt_key;
  end

  assign ALL_DONE  = done_q;
  assign KEY_COUNT = kcnt_q;

endmodule
